// File: rtl/cnn_dispatch_multi_if.sv
// cnn_dispatch_multi_if: image stream, core load/start/done bus and prediction stream
// for the CNN core-array dispatcher. Perf counter outputs exist only with DISPATCH_PERF_EN.
interface cnn_dispatch_multi_if #(
  parameter int N_CORES   = 4,
  parameter int IMG_WORDS = 64,
  parameter int DATA_W    = 32,
  parameter int OUT_W     = 32
);
  localparam int CW = $clog2(N_CORES);
  localparam int AW = $clog2(IMG_WORDS);

  logic                          img_valid;
  logic                          img_ready;
  logic [DATA_W-1:0]             img_data;
  logic                          img_last;
  logic [N_CORES-1:0]            core_wr_en;
  logic [AW-1:0]                 core_wr_addr;
  logic [DATA_W-1:0]             core_wr_data;
  logic [N_CORES-1:0]            core_start;
  logic [N_CORES-1:0]            core_done;
  logic [N_CORES-1:0][OUT_W-1:0] core_pred;
  logic                          pred_valid;
  logic                          pred_ready;
  logic [OUT_W-1:0]              pred_data;
  logic [CW-1:0]                 pred_core;
  logic                          all_done;
  logic                          err_len;
`ifdef DISPATCH_PERF_EN
  logic [31:0]                   perf_imgs;
  logic [31:0]                   perf_stall;
`endif

  // dispatcher side
  modport slave (
    input  img_valid, img_data, img_last, core_done, core_pred, pred_ready,
    output img_ready, core_wr_en, core_wr_addr, core_wr_data, core_start,
           pred_valid, pred_data, pred_core, all_done, err_len
`ifdef DISPATCH_PERF_EN
    , output perf_imgs, perf_stall
`endif
  );

  // image source / core array / prediction sink side
  modport master (
    output img_valid, img_data, img_last, core_done, core_pred, pred_ready,
    input  img_ready, core_wr_en, core_wr_addr, core_wr_data, core_start,
           pred_valid, pred_data, pred_core, all_done, err_len
`ifdef DISPATCH_PERF_EN
    , input perf_imgs, perf_stall
`endif
  );
endinterface

// File: rtl/cnn_dispatch_multi.sv
// cnn_dispatch_multi: loads streamed images into free CNN cores (round-robin), starts them,
// captures predictions on done and returns them in submission order.
// Optional feature macro: DISPATCH_PERF_EN (perf_imgs / perf_stall counters).
module cnn_dispatch_multi #(
  parameter int N_CORES   = 4,
  parameter int IMG_WORDS = 64,
  parameter int DATA_W    = 32,
  parameter int OUT_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  cnn_dispatch_multi_if.slave bus
);
  localparam int CW = $clog2(N_CORES);
  localparam int AW = $clog2(IMG_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, START} state_t;

  state_t                        state, nstate;
  logic [CW-1:0]                 sel, rr_ptr, fsel, head, wp, rp;
  logic [AW-1:0]                 cnt;
  logic [CW:0]                   fcnt;
  logic                          found, alloc, accept, last_addr, pop, img_ready, pad_go;
  logic [N_CORES-1:0]            busy, running, res_v, sel_oh;
  logic [N_CORES-1:0][OUT_W-1:0] res;
  logic [N_CORES-1:0][CW-1:0]    order;
  logic [N_CORES-1:0]            wr_en_q, start_q;
  logic [AW-1:0]                 wr_addr_q;
  logic [DATA_W-1:0]             wr_data_q;
  logic                          err_q;

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] p);
    return (p == CW'(N_CORES-1)) ? '0 : p + CW'(1);
  endfunction

  // first free core at or after rr_ptr; descending loop so the nearest one wins
  always_comb begin
    found = 1'b0;
    fsel  = '0;
    for (int i = N_CORES-1; i >= 0; i--) begin
      if (!busy[(int'(rr_ptr) + i) % N_CORES]) begin
        found = 1'b1;
        fsel  = CW'((int'(rr_ptr) + i) % N_CORES);
      end
    end
  end

  assign sel_oh    = {{(N_CORES-1){1'b0}}, 1'b1} << sel;
  assign accept    = bus.img_valid & img_ready;
  assign last_addr = (cnt == AW'(IMG_WORDS-1));
  assign head      = order[rp];
  assign pop       = bus.pred_valid & bus.pred_ready;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // next state; a word at the last address always closes the image, flagged or not
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (alloc) nstate = LOAD;
      LOAD:  if (accept && (bus.img_last || last_addr))
               nstate = (bus.img_last && !last_addr) ? PAD : START;
      PAD:   if (last_addr) nstate = START;
      START: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM outputs; a core is only reserved once an image is actually offered,
  // so an idle dispatcher with nothing queued reports all_done
  always_comb begin
    img_ready = (state == LOAD);
    alloc     = (state == IDLE) && bus.img_valid && found;
    pad_go    = (state == PAD);
  end

  // selection, word counter, registered write bus, start pulse, length error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= '0;
      start_q <= (state == START) ? sel_oh : '0;
      if (alloc) begin
        sel    <= fsel;
        rr_ptr <= wrap_inc(fsel);
        cnt    <= '0;
      end
      if (accept || pad_go) begin
        wr_en_q   <= sel_oh;
        wr_addr_q <= cnt;
        wr_data_q <= accept ? bus.img_data : '0;
        cnt       <= cnt + AW'(1);
      end
      if (accept && (bus.img_last != last_addr)) err_q <= 1'b1;
    end
  end

  // per-core reservation / run / result tracking; done from a non-running core is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      running <= '0;
      res_v   <= '0;
      res     <= '0;
    end else begin
      for (int k = 0; k < N_CORES; k++) begin
        if (alloc && fsel == CW'(k)) busy[k] <= 1'b1;
        if (pop && head == CW'(k)) begin
          busy[k]  <= 1'b0;
          res_v[k] <= 1'b0;
        end
        if (state == START && sel == CW'(k)) running[k] <= 1'b1;
        if (bus.core_done[k] && running[k]) begin
          running[k] <= 1'b0;
          res_v[k]   <= 1'b1;
          res[k]     <= bus.core_pred[k];
        end
      end
    end
  end

  // submission-order FIFO of core indices; never overflows since entries == reserved cores
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      order <= '0;
      wp    <= '0;
      rp    <= '0;
      fcnt  <= '0;
    end else begin
      if (alloc) begin
        order[wp] <= fsel;
        wp        <= wrap_inc(wp);
      end
      if (pop) rp <= wrap_inc(rp);
      case ({alloc, pop})
        2'b10:   fcnt <= fcnt + (CW+1)'(1);
        2'b01:   fcnt <= fcnt - (CW+1)'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  assign bus.img_ready    = img_ready;
  assign bus.core_wr_en   = wr_en_q;
  assign bus.core_wr_addr = wr_addr_q;
  assign bus.core_wr_data = wr_data_q;
  assign bus.core_start   = start_q;
  assign bus.pred_valid   = (fcnt != '0) && res_v[head];
  assign bus.pred_data    = res[head];
  assign bus.pred_core    = head;
  assign bus.err_len      = err_q;
  // gated by rst so it reads 0 while reset is held
  assign bus.all_done     = rst && (state == IDLE) && (fcnt == '0);

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_imgs_q, perf_stall_q;

  // popped predictions and IDLE cycles blocked by a full core array; both wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_imgs_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop) perf_imgs_q <= perf_imgs_q + 32'd1;
      if (state == IDLE && bus.img_valid && !found) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_imgs  = perf_imgs_q;
  assign bus.perf_stall = perf_stall_q;
`else
  // no performance counters in this build
`endif
endmodule
